// File: rtl/vm2_irq_arbiter_pkg.sv
// vm2_irq_arbiter_pkg: shared state encoding, default spurious vector and index-width helper
package vm2_irq_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
  localparam logic [15:0] SPUR_DEFAULT = 16'o000000;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins
module irq_prio_enc import vm2_irq_arbiter_pkg::*; #(
  parameter int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] pending,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = pending[i] ? i[W-1:0] : idx;
  end
  assign valid = |pending;
endmodule

// File: rtl/vm2_irq_arbiter.sv
// vm2_irq_arbiter: vectored interrupt arbiter driving the VM2 virq/ivec/iack handshake
module vm2_irq_arbiter import vm2_irq_arbiter_pkg::*; #(
  parameter int            N       = 8,
  parameter logic [16*N-1:0] VECTORS = '0,
  parameter logic [15:0]   SPUR    = SPUR_DEFAULT
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [N-1:0] irq_req,
  output logic [N-1:0] irq_ack,
  output logic         virq,
  output logic [15:0]  ivec,
  input  logic         istb,
  output logic         iack
);
  localparam int W = idx_w(N);
  state_t       state;
  logic [N-1:0] served, pending, win_hot;
  logic [W-1:0] win;
  logic         valid;
  assign pending = irq_req & ~served;
  assign win_hot = N'(1) << win;
  irq_prio_enc #(.N(N)) u_enc (.pending(pending), .idx(win), .valid(valid));
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      virq    <= 1'b0;
      iack    <= 1'b0;
      ivec    <= '0;
      irq_ack <= '0;
      served  <= '0;
    end else begin
      served  <= served & irq_req;
      irq_ack <= '0;
      if (state == IDLE) begin
        virq <= |pending;
        if (istb) begin
          ivec    <= valid ? VECTORS[16*win +: 16] : SPUR;
          irq_ack <= valid ? win_hot : '0;
          served  <= (served & irq_req) | (valid ? win_hot : '0);
          iack    <= 1'b1;
          virq    <= 1'b0;
          state   <= ACK;
        end
      end else begin
        virq <= 1'b0;
        if (!istb) begin
          iack  <= 1'b0;
          ivec  <= '0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_vm2_irq_arbiter.sv
// tb_vm2_irq_arbiter: directed vector table plus randomized run against a transaction-level model
module tb_vm2_irq_arbiter;
  localparam int N = 8;
  localparam logic [16*N-1:0] VECS = {16'o130, 16'o120, 16'o100, 16'o110, 16'o060, 16'o070, 16'o064, 16'o200};
  logic        clk = 1'b0, rst = 1'b1, istb = 1'b0;
  logic [7:0]  req = '0, irq_ack;
  logic        virq, iack;
  logic [15:0] ivec;
  int checks = 0, errors = 0;
  vm2_irq_arbiter #(.N(N), .VECTORS(VECS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .irq_req(req), .irq_ack(irq_ack),
    .virq(virq), .ivec(ivec), .istb(istb), .iack(iack)
  );
  always #5 clk = ~clk;
  logic [15:0] vtab [N] = '{16'o200, 16'o064, 16'o070, 16'o060, 16'o110, 16'o100, 16'o120, 16'o130};
  bit          m_busy, m_virq, m_iack;
  bit          m_served [N];
  logic [15:0] m_ivec;
  logic [7:0]  m_ack;
  function automatic void model(input logic r, input logic [7:0] q, input logic s);
    int w;
    bit any;
    if (r) begin
      m_busy = 0; m_virq = 0; m_iack = 0; m_ivec = '0; m_ack = '0;
      foreach (m_served[i]) m_served[i] = 0;
      return;
    end
    w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && q[i] && !m_served[i]) w = i;
    any = w >= 0;
    for (int i = 0; i < N; i++) if (!q[i]) m_served[i] = 0;
    m_ack = '0;
    if (m_busy) begin
      m_virq = 0;
      if (!s) begin m_busy = 0; m_iack = 0; m_ivec = '0; end
    end else if (s) begin
      m_busy = 1; m_iack = 1; m_virq = 0;
      m_ivec = any ? vtab[w] : 16'o000000;
      if (any) begin m_ack[w] = 1'b1; m_served[w] = 1; end
    end else m_virq = any;
  endfunction
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0o expected %0o", n, $time, a, e);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] q, input logic s);
    rst = r; req = q; istb = s;
    model(r, q, s);
    @(posedge clk);
    #1;
  endtask
  typedef struct packed {
    logic r; logic [7:0] q; logic s;
    logic v; logic a; logic [15:0] iv; logic [7:0] k;
  } vec_t;
  vec_t tbl [$];
  initial begin
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h08, 1'b1, 1'b0, 1'b1, 16'o060, 8'h08});
    tbl.push_back('{1'b0, 8'h08, 1'b1, 1'b0, 1'b1, 16'o060, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 16'o064, 8'h02});
    tbl.push_back('{1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 16'o100, 8'h20});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 16'o070, 8'h04});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 16'o000, 8'h00});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 16'o070, 8'h04});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h10, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 16'o110, 8'h10});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'o110, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'o110, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'o200, 8'h01});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'o200, 8'h00});
    tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 16'o000, 8'h00});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'o200, 8'h01});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'o000, 8'h00});
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].s);
      chk($sformatf("row%0d virq", i), 16'(virq), 16'(tbl[i].v));
      chk($sformatf("row%0d iack", i), 16'(iack), 16'(tbl[i].a));
      chk($sformatf("row%0d ivec", i), ivec, tbl[i].iv);
      chk($sformatf("row%0d irq_ack", i), 16'(irq_ack), 16'(tbl[i].k));
    end
    begin
      logic [7:0] q;
      logic s, r;
      q = '0; s = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        r = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 3) == 0) q = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 2) == 0) s = ~s;
        step(r, q, s);
        chk("rand virq", 16'(virq), 16'(m_virq));
        chk("rand iack", 16'(iack), 16'(m_iack));
        chk("rand ivec", ivec, m_ivec);
        chk("rand irq_ack", 16'(irq_ack), 16'(m_ack));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
